// File: rtl/ctrl_decode_pipe_if.sv
// rtl/ctrl_decode_pipe_if.sv - D-side handshake and E-side control bundle for ctrl_decode_pipe
interface ctrl_decode_pipe_if #(
  parameter int ALU_CTRL_W = 11
);
  logic [31:0]           instr_D;
  logic                  valid_D;
  logic                  ready_D;
  logic                  stall_E;
  logic                  flush_E;
  logic                  valid_E;
  logic [1:0]            jump_E;
  logic                  branch_E;
  logic [2:0]            bropcode_E;
  logic [2:0]            imm_sel_E;
  logic [1:0]            store_sel_E;
  logic [2:0]            load_sel_E;
  logic [ALU_CTRL_W-1:0] alu_ctrl_E;
  logic                  alu_srcA_E;
  logic                  alu_srcB_E;
  logic                  regWrite_E;
  logic                  memWrite_E;
  logic [1:0]            write_back_E;
  logic [2:0]            muldiv_op_E;
  logic                  muldiv_busy_E;
  logic                  illegal_E;

  // Fetch/hazard side: supplies the instruction and pipeline control
  modport master (
    output instr_D, valid_D, stall_E, flush_E,
    input  ready_D, valid_E, jump_E, branch_E, bropcode_E, imm_sel_E, store_sel_E,
           load_sel_E, alu_ctrl_E, alu_srcA_E, alu_srcB_E, regWrite_E, memWrite_E,
           write_back_E, muldiv_op_E, muldiv_busy_E, illegal_E
  );

  // Decode stage side
  modport slave (
    input  instr_D, valid_D, stall_E, flush_E,
    output ready_D, valid_E, jump_E, branch_E, bropcode_E, imm_sel_E, store_sel_E,
           load_sel_E, alu_ctrl_E, alu_srcA_E, alu_srcB_E, regWrite_E, memWrite_E,
           write_back_E, muldiv_op_E, muldiv_busy_E, illegal_E
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// rtl/ctrl_decode_pipe.sv - RV32I(M) decode into D->E register with stall/flush and M-op sequencer; optional CTRL_MEXT_EN
module ctrl_decode_pipe #(
  parameter int ALU_CTRL_W    = 11,
  parameter int MULDIV_CYCLES = 4
) (
  input logic               clk,
  input logic               rst,
  ctrl_decode_pipe_if.slave bus
);

  localparam int CNT_W = $clog2(MULDIV_CYCLES) + 1;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam int A_ADD = 0, A_SUB = 1, A_SLL = 2, A_SLT = 3, A_SLTU = 4, A_XOR = 5;
  localparam int A_SRL = 6, A_SRA = 7, A_OR = 8, A_AND = 9, A_MD = 10;

  typedef enum logic {IDLE, MULDIV} state_t;

  typedef struct packed {
    logic                  valid;
    logic [1:0]            jump;
    logic                  branch;
    logic [2:0]            bropcode;
    logic [2:0]            imm_sel;
    logic [1:0]            store_sel;
    logic [2:0]            load_sel;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  alu_srcA;
    logic                  alu_srcB;
    logic                  regWrite;
    logic                  memWrite;
    logic [1:0]            write_back;
    logic [2:0]            muldiv_op;
    logic                  illegal;
  } ctrl_t;

  // A bubble is all-zero except the "no memory access" encodings
  function automatic ctrl_t bubble_word();
    ctrl_t w;
    w           = '0;
    w.store_sel = 2'b11;
    w.load_sel  = 3'b111;
    return w;
  endfunction

  // Base-ALU op from funct3; alt selects sub/sra on the 000/101 encodings
  function automatic logic [10:0] alu_by_f3(input logic [2:0] f3, input logic alt);
    logic [10:0] a;
    a = '0;
    case (f3)
      3'b000:  a[alt ? A_SUB : A_ADD] = 1'b1;
      3'b001:  a[A_SLL]  = 1'b1;
      3'b010:  a[A_SLT]  = 1'b1;
      3'b011:  a[A_SLTU] = 1'b1;
      3'b100:  a[A_XOR]  = 1'b1;
      3'b101:  a[alt ? A_SRA : A_SRL] = 1'b1;
      3'b110:  a[A_OR]   = 1'b1;
      default: a[A_AND]  = 1'b1;
    endcase
    return a;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  ctrl_t            r_e;

  ctrl_t       w_dec;
  logic [10:0] w_alu;
  logic        w_ill;
  logic        w_is_m;
  logic        w_accept;
  logic        w_start_md;
  logic        w_unused_ok;

  wire [6:0] w_opcode = bus.instr_D[6:0];
  wire [2:0] w_f3     = bus.instr_D[14:12];
  wire [6:0] w_f7     = bus.instr_D[31:25];

  // Register/immediate fields are consumed by the datapath, not here
  assign w_unused_ok = ^{bus.instr_D[24:15], bus.instr_D[11:7]};

  // Combinational decode of the instruction in D into a full control word
  always_comb begin
    w_dec       = bubble_word();
    w_dec.valid = 1'b1;
    w_alu       = '0;
    w_ill       = 1'b0;
    w_is_m      = 1'b0;
    case (w_opcode)
      OP_R: begin
        w_dec.regWrite = 1'b1;
        case (w_f7)
          7'b0000000: w_alu = alu_by_f3(w_f3, 1'b0);
          7'b0100000: begin
            if (w_f3 == 3'b000 || w_f3 == 3'b101) w_alu = alu_by_f3(w_f3, 1'b1);
            else w_ill = 1'b1;
          end
`ifdef CTRL_MEXT_EN
          7'b0000001: begin
            w_is_m          = 1'b1;
            w_alu[A_MD]     = 1'b1;
            w_dec.muldiv_op = w_f3;
          end
`endif
          default: w_ill = 1'b1;
        endcase
      end
      OP_I: begin
        w_dec.regWrite = 1'b1;
        w_dec.alu_srcB = 1'b1;
        if (w_f3 == 3'b001) begin
          w_dec.imm_sel = 3'b101;
          w_alu[A_SLL]  = 1'b1;
          if (w_f7 != 7'b0000000) w_ill = 1'b1;
        end else if (w_f3 == 3'b101) begin
          w_dec.imm_sel = 3'b101;
          if (w_f7 == 7'b0000000) w_alu[A_SRL] = 1'b1;
          else if (w_f7 == 7'b0100000) w_alu[A_SRA] = 1'b1;
          else w_ill = 1'b1;
        end else begin
          w_alu = alu_by_f3(w_f3, 1'b0);
        end
      end
      OP_LOAD: begin
        w_alu[A_ADD]     = 1'b1;
        w_dec.alu_srcB   = 1'b1;
        w_dec.regWrite   = 1'b1;
        w_dec.write_back = 2'b01;
        case (w_f3)
          3'b000:  w_dec.load_sel = 3'b010;
          3'b001:  w_dec.load_sel = 3'b001;
          3'b010:  w_dec.load_sel = 3'b000;
          3'b100:  w_dec.load_sel = 3'b100;
          3'b101:  w_dec.load_sel = 3'b011;
          default: w_ill = 1'b1;
        endcase
      end
      OP_S: begin
        w_alu[A_ADD]   = 1'b1;
        w_dec.alu_srcB = 1'b1;
        w_dec.memWrite = 1'b1;
        w_dec.imm_sel  = 3'b001;
        case (w_f3)
          3'b000:  w_dec.store_sel = 2'b10;
          3'b001:  w_dec.store_sel = 2'b01;
          3'b010:  w_dec.store_sel = 2'b00;
          default: w_ill = 1'b1;
        endcase
      end
      OP_B: begin
        w_alu[A_SUB]   = 1'b1;
        w_dec.branch   = 1'b1;
        w_dec.bropcode = w_f3;
        w_dec.imm_sel  = 3'b010;
        if (w_f3 == 3'b010 || w_f3 == 3'b011) w_ill = 1'b1;
      end
      OP_LUI: begin
        w_alu[A_ADD]     = 1'b1;
        w_dec.alu_srcB   = 1'b1;
        w_dec.imm_sel    = 3'b011;
        w_dec.regWrite   = 1'b1;
        w_dec.write_back = 2'b11;
      end
      OP_AUIPC: begin
        w_alu[A_ADD]   = 1'b1;
        w_dec.alu_srcA = 1'b1;
        w_dec.alu_srcB = 1'b1;
        w_dec.imm_sel  = 3'b011;
        w_dec.regWrite = 1'b1;
      end
      OP_JAL: begin
        w_alu[A_ADD]     = 1'b1;
        w_dec.jump       = 2'b01;
        w_dec.alu_srcA   = 1'b1;
        w_dec.alu_srcB   = 1'b1;
        w_dec.imm_sel    = 3'b100;
        w_dec.regWrite   = 1'b1;
        w_dec.write_back = 2'b10;
      end
      OP_JALR: begin
        w_alu[A_ADD]     = 1'b1;
        w_dec.jump       = 2'b10;
        w_dec.alu_srcB   = 1'b1;
        w_dec.regWrite   = 1'b1;
        w_dec.write_back = 2'b10;
      end
      default: w_ill = 1'b1;
    endcase
    w_dec.alu_ctrl = ALU_CTRL_W'(w_alu);
    // Illegal ops travel down the pipe as a valid, side-effect-free word
    if (w_ill) begin
      w_dec         = bubble_word();
      w_dec.valid   = 1'b1;
      w_dec.illegal = 1'b1;
      w_is_m        = 1'b0;
    end
  end

  assign bus.ready_D = (r_state == IDLE) && !bus.stall_E;
  assign w_accept    = bus.valid_D && bus.ready_D;

`ifdef CTRL_MEXT_EN
  assign w_start_md        = w_is_m && (MULDIV_CYCLES > 1);
  assign bus.muldiv_busy_E = (r_state == MULDIV);
`else
  assign w_start_md        = 1'b0;
  assign bus.muldiv_busy_E = 1'b0;
`endif

  // Sequencer: holds E for MULDIV_CYCLES-1 cycles after an M op is captured
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else if (bus.flush_E) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && w_start_md) begin
            r_state <= MULDIV;
            r_cnt   <= CNT_W'(MULDIV_CYCLES - 1);
          end
        end
        default: begin
          if (r_cnt == CNT_W'(1)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  // D->E pipeline register: flush > stall > M-op hold > accept > bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_e <= bubble_word();
    end else if (bus.flush_E) begin
      r_e <= bubble_word();
    end else if (bus.stall_E || r_state == MULDIV) begin
      r_e <= r_e;
    end else if (w_accept) begin
      r_e <= w_dec;
    end else begin
      r_e <= bubble_word();
    end
  end

  assign bus.valid_E      = r_e.valid;
  assign bus.jump_E       = r_e.jump;
  assign bus.branch_E     = r_e.branch;
  assign bus.bropcode_E   = r_e.bropcode;
  assign bus.imm_sel_E    = r_e.imm_sel;
  assign bus.store_sel_E  = r_e.store_sel;
  assign bus.load_sel_E   = r_e.load_sel;
  assign bus.alu_ctrl_E   = r_e.alu_ctrl;
  assign bus.alu_srcA_E   = r_e.alu_srcA;
  assign bus.alu_srcB_E   = r_e.alu_srcB;
  assign bus.regWrite_E   = r_e.regWrite;
  assign bus.memWrite_E   = r_e.memWrite;
  assign bus.write_back_E = r_e.write_back;
  assign bus.muldiv_op_E  = r_e.muldiv_op;
  assign bus.illegal_E    = r_e.illegal;

endmodule
